ophd_arbiter: RTL and testbench

- Parametrised successor of the op-head decoder stage.
- At each instruction head it arbitrates bus request, NMI, and N_INT maskable interrupt channels. Fixed priority: BUSRQ > NMI > INT[0] > … > INT[N_INT-1].
- Unlike the single-channel combinational decoder, it sequences bus hold and acknowledge cycles with an FSM.
- It owns the NMI edge latch and the IFF1/IFF2 flip-flops. It sits between the fetch sequencer, which supplies opHead, and the instruction decoder, which consumes decodeRun.

---
 rtl/ophd_arbiter_if.sv | 62 ++++++
 rtl/ophd_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ophd_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ophd_arbiter_if.sv
// rtl/ophd_arbiter_if.sv - op-head arbiter request/grant bundle
//
// Groups everything between the fetch sequencer / instruction decoder side
// and the arbiter. Clock and reset are not part of the bundle.
//
//   slave  modport : arbiter side (requests in, grants/status out)
//   master modport : fetch/decode side (requests out, grants/status in)
//
//   opHead      instruction boundary strobe
//   BUSRQ       external bus request (level)
//   NMI         non-maskable request (rising edge)
//   INT         maskable request channels (level)
//   intMask     per-channel mask, 1 = masked
//   IMF         interrupt mode select
//   setIFF      EI executed
//   resetIFF    DI executed
//   restoreIFF  RETN executed
//   busak       bus granted
//   haltXpt     execution halted while bus is held
//   nmiAck      NMI acknowledge phase
//   intAck      INT acknowledge phase
//   intMode     one-hot interrupt mode captured at acceptance
//   intId       accepted channel index
//   resetHalt   HALT-latch clear pulse
//   iff1, iff2  interrupt enable flip-flops
//   decodeRun   proceed-with-decode pulse
interface ophd_arbiter_if #(
  parameter int N_INT = 4,
  parameter int ID_W  = 4
);
  logic             opHead;
  logic             BUSRQ;
  logic             NMI;
  logic [N_INT-1:0] INT;
  logic [N_INT-1:0] intMask;
  logic [1:0]       IMF;
  logic             setIFF;
  logic             resetIFF;
  logic             restoreIFF;
  logic             busak;
  logic             haltXpt;
  logic             nmiAck;
  logic             intAck;
  logic [2:0]       intMode;
  logic [ID_W-1:0]  intId;
  logic             resetHalt;
  logic             iff1;
  logic             iff2;
  logic             decodeRun;

  modport slave (
    input  opHead, BUSRQ, NMI, INT, intMask, IMF, setIFF, resetIFF, restoreIFF,
    output busak, haltXpt, nmiAck, intAck, intMode, intId, resetHalt,
           iff1, iff2, decodeRun
  );

  modport master (
    output opHead, BUSRQ, NMI, INT, intMask, IMF, setIFF, resetIFF, restoreIFF,
    input  busak, haltXpt, nmiAck, intAck, intMode, intId, resetHalt,
           iff1, iff2, decodeRun
  );
endinterface

// File: rtl/ophd_arbiter.sv
// rtl/ophd_arbiter.sv - instruction-head arbiter for bus request, NMI and maskable interrupts
//
// At every instruction head the arbiter picks, in fixed priority,
// BUSRQ > NMI > INT[0] > ... > INT[N_INT-1], or lets normal decode proceed.
// Bus hold and acknowledge phases are sequenced by a small FSM; all outputs
// are registered, so a decision shows up the cycle after the evaluating edge.
// The arbiter owns the NMI edge latch and the IFF1/IFF2 flip-flops.
//
// Optional build macro: OPHD_EI_DELAY_EN - maskable interrupts are held off
// for the first head after EI (NMI and BUSRQ unaffected).
//
// Ports:
//   Clk       system clock, rising edge
//   notReset  asynchronous active-low reset
//   bus       ophd_arbiter_if.slave (requests in, grants/status out)
//
// Parameters:
//   N_INT       maskable channels (1..16)
//   ACK_CYCLES  acknowledge phase length in clocks (1..15)
//   ID_W        intId width, 2**ID_W >= N_INT
module ophd_arbiter #(
  parameter int N_INT      = 4,
  parameter int ACK_CYCLES = 2,
  parameter int ID_W       = 4
) (
  input  logic           Clk,
  input  logic           notReset,
  ophd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_NMI  = 2'd2,
    S_INTA = 2'd3
  } state_t;

  localparam logic [3:0] ACK_LAST = 4'(ACK_CYCLES - 1);

  state_t state_q, state_d;

  logic             busak_q,      busak_d;
  logic             nmi_ack_q,    nmi_ack_d;
  logic             int_ack_q,    int_ack_d;
  logic [2:0]       int_mode_q,   int_mode_d;
  logic [ID_W-1:0]  int_id_q,     int_id_d;
  logic             reset_halt_q, reset_halt_d;
  logic             iff1_q,       iff1_d;
  logic             iff2_q,       iff2_d;
  logic             decode_run_q, decode_run_d;
  logic             tnmi_q,       tnmi_d;
  logic             nmi_prev_q;
  logic             head_pend_q,  head_pend_d;
  logic [3:0]       ack_cnt_q,    ack_cnt_d;

  logic             head;
  logic [N_INT-1:0] int_req;
  logic             int_ok;
  logic [ID_W-1:0]  sel_id;
  logic [2:0]       imf_onehot;
  logic             evaluate;
  logic             take_bus, take_nmi, take_int, take_run;
  logic             in_ack, ack_last, ack_done;

  assign head    = bus.opHead | head_pend_q;
  assign int_req = bus.INT & ~bus.intMask & {N_INT{iff1_q}};

`ifdef OPHD_EI_DELAY_EN
  logic ei_shadow_q, ei_shadow_d;
  // The head right after EI lets the next instruction run before any
  // maskable interrupt can break in.
  assign int_ok = (|int_req) & ~ei_shadow_q;
`else
  assign int_ok = |int_req;
`endif

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    sel_id = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (int_req[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    imf_onehot = 3'b001;
    if (bus.IMF[1])      imf_onehot = 3'b100;
    else if (bus.IMF[0]) imf_onehot = 3'b010;
  end

  assign evaluate = (state_q == S_IDLE) && head;
  assign take_bus = evaluate & bus.BUSRQ;
  assign take_nmi = evaluate & ~bus.BUSRQ & tnmi_q;
  assign take_int = evaluate & ~bus.BUSRQ & ~tnmi_q & int_ok;
  assign take_run = evaluate & ~bus.BUSRQ & ~tnmi_q & ~int_ok;

  assign in_ack   = (state_q == S_NMI) || (state_q == S_INTA);
  assign ack_last = (ack_cnt_q == ACK_LAST);
  assign ack_done = in_ack && ack_last;

  // State register
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_bus)      state_d = S_BUS;
        else if (take_nmi) state_d = S_NMI;
        else if (take_int) state_d = S_INTA;
      end
      S_BUS:  if (!bus.BUSRQ) state_d = S_IDLE;
      S_NMI:  if (ack_last)   state_d = S_IDLE;
      S_INTA: if (ack_last)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    busak_d      = (state_d == S_BUS);
    nmi_ack_d    = (state_d == S_NMI);
    int_ack_d    = (state_d == S_INTA);
    reset_halt_d = take_nmi | take_int;
    decode_run_d = take_run;
    int_id_d     = int_id_q;
    int_mode_d   = int_mode_q;
    iff1_d       = iff1_q;
    iff2_d       = iff2_q;
    head_pend_d  = head_pend_q;
    ack_cnt_d    = '0;

    if (take_int) begin
      int_id_d   = sel_id;
      int_mode_d = imf_onehot;
    end

    // Acceptance overrides any EI/DI/RETN executed in the same cycle.
    if (take_int) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (take_nmi) begin
      iff1_d = 1'b0;
      iff2_d = iff1_q;
    end else if (bus.resetIFF) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (bus.setIFF) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end else if (bus.restoreIFF) begin
      iff1_d = iff2_q;
    end

    // A BUS grant keeps the head pending so arbitration repeats after release.
    if (take_run || ack_done) head_pend_d = 1'b0;
    else if (bus.opHead)      head_pend_d = 1'b1;

    if (in_ack && !ack_last) ack_cnt_d = ack_cnt_q + 4'd1;
  end

  // A fresh edge in the accepting cycle must survive the clear.
  assign tnmi_d = (bus.NMI & ~nmi_prev_q) | (tnmi_q & ~take_nmi);

`ifdef OPHD_EI_DELAY_EN
  always_comb begin
    ei_shadow_d = ei_shadow_q;
    if (bus.setIFF)    ei_shadow_d = 1'b1;
    else if (evaluate) ei_shadow_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) ei_shadow_q <= 1'b0;
    else           ei_shadow_q <= ei_shadow_d;
  end
`endif

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      busak_q      <= 1'b0;
      nmi_ack_q    <= 1'b0;
      int_ack_q    <= 1'b0;
      int_mode_q   <= '0;
      int_id_q     <= '0;
      reset_halt_q <= 1'b0;
      iff1_q       <= 1'b0;
      iff2_q       <= 1'b0;
      decode_run_q <= 1'b0;
      tnmi_q       <= 1'b0;
      nmi_prev_q   <= 1'b0;
      head_pend_q  <= 1'b0;
      ack_cnt_q    <= '0;
    end else begin
      busak_q      <= busak_d;
      nmi_ack_q    <= nmi_ack_d;
      int_ack_q    <= int_ack_d;
      int_mode_q   <= int_mode_d;
      int_id_q     <= int_id_d;
      reset_halt_q <= reset_halt_d;
      iff1_q       <= iff1_d;
      iff2_q       <= iff2_d;
      decode_run_q <= decode_run_d;
      tnmi_q       <= tnmi_d;
      nmi_prev_q   <= bus.NMI;
      head_pend_q  <= head_pend_d;
      ack_cnt_q    <= ack_cnt_d;
    end
  end

  assign bus.busak     = busak_q;
  assign bus.haltXpt   = busak_q;
  assign bus.nmiAck    = nmi_ack_q;
  assign bus.intAck    = int_ack_q;
  assign bus.intMode   = int_mode_q;
  assign bus.intId     = int_id_q;
  assign bus.resetHalt = reset_halt_q;
  assign bus.iff1      = iff1_q;
  assign bus.iff2      = iff2_q;
  assign bus.decodeRun = decode_run_q;

endmodule

// File: tb/tb_ophd_arbiter.sv
// tb/tb_ophd_arbiter.sv - self-checking bench for ophd_arbiter
module tb_ophd_arbiter;
  localparam int N_INT      = 4;
  localparam int ACK_CYCLES = 2;
  localparam int ID_W       = 4;

  logic Clk      = 1'b0;
  logic notReset = 1'b0;

  ophd_arbiter_if #(.N_INT(N_INT), .ID_W(ID_W)) bus ();

  ophd_arbiter #(.N_INT(N_INT), .ACK_CYCLES(ACK_CYCLES), .ID_W(ID_W)) dut (
    .Clk      (Clk),
    .notReset (notReset),
    .bus      (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference state
  logic            m_iff1, m_iff2, m_tnmi, m_shadow;
  logic [ID_W-1:0] m_id;
  logic [2:0]      m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic model_reset();
    m_iff1 = 0; m_iff2 = 0; m_tnmi = 0; m_shadow = 0; m_id = '0; m_mode = '0;
  endtask

  function automatic logic [ID_W-1:0] lowest(input logic [N_INT-1:0] v);
    for (int i = 0; i < N_INT; i++) if (v[i]) return ID_W'(i);
    return '0;
  endfunction

  function automatic logic [2:0] mode_of(input logic [1:0] imf);
    if (imf >= 2) return 3'b100;
    if (imf == 1) return 3'b010;
    return 3'b001;
  endfunction

  // 1 = EI, 2 = DI, 3 = RETN, one cycle each
  task automatic iff_op(input int op);
    bus.setIFF = (op == 1); bus.resetIFF = (op == 2); bus.restoreIFF = (op == 3);
    tick();
    bus.setIFF = 0; bus.resetIFF = 0; bus.restoreIFF = 0;
    case (op)
      1: begin
        m_iff1 = 1; m_iff2 = 1;
`ifdef OPHD_EI_DELAY_EN
        m_shadow = 1;
`endif
      end
      2: begin m_iff1 = 0; m_iff2 = 0; end
      3: m_iff1 = m_iff2;
      default: ;
    endcase
    check("iff1_after_op", bus.iff1, m_iff1);
    check("iff2_after_op", bus.iff2, m_iff2);
  endtask

  task automatic nmi_edge();
    bus.NMI = 1; tick();
    bus.NMI = 0; tick();
    m_tnmi = 1;
  endtask

  // Issue one opHead, optionally with BUSRQ held for 'hold' cycles, and check
  // the whole response against the priority rules. kind: 0 run, 1 NMI, 2 INT.
  task automatic head(input int hold, output int kind);
    logic [N_INT-1:0] req;
    bus.opHead = 1; bus.BUSRQ = (hold > 0);
    tick();
    bus.opHead = 0;
    if (hold > 0) begin
      for (int k = 1; k <= hold; k++) begin
        check("busak_held", bus.busak, 1);
        check("haltXpt_held", bus.haltXpt, 1);
        check("no_decode_in_bus", bus.decodeRun, 0);
        if (k == hold) bus.BUSRQ = 0;
        tick();
      end
      check("busak_released", bus.busak, 0);
      check("haltXpt_released", bus.haltXpt, 0);
      m_shadow = 0;
      tick();
    end
    req = bus.INT & ~bus.intMask;
    if (m_tnmi) kind = 1;
    else if (m_iff1 && (req != 0) && !m_shadow) kind = 2;
    else kind = 0;
    m_shadow = 0;
    if (kind == 1) begin
      m_tnmi = 0; m_iff2 = m_iff1; m_iff1 = 0;
    end else if (kind == 2) begin
      m_id = lowest(req); m_mode = mode_of(bus.IMF); m_iff1 = 0; m_iff2 = 0;
    end
    check("decodeRun", bus.decodeRun, kind == 0);
    check("nmiAck", bus.nmiAck, kind == 1);
    check("intAck", bus.intAck, kind == 2);
    check("resetHalt", bus.resetHalt, kind != 0);
    check("intId", bus.intId, m_id);
    check("intMode", bus.intMode, m_mode);
    check("iff1", bus.iff1, m_iff1);
    check("iff2", bus.iff2, m_iff2);
    check("busak_idle", bus.busak, 0);
    if (kind != 0) begin
      for (int c = 1; c < ACK_CYCLES; c++) begin
        tick();
        check("nmiAck_hold", bus.nmiAck, kind == 1);
        check("intAck_hold", bus.intAck, kind == 2);
        check("resetHalt_once", bus.resetHalt, 0);
        check("intId_hold", bus.intId, m_id);
        check("intMode_hold", bus.intMode, m_mode);
        check("no_decode_in_ack", bus.decodeRun, 0);
      end
      tick();
      check("nmiAck_end", bus.nmiAck, 0);
      check("intAck_end", bus.intAck, 0);
      check("no_decode_after_ack", bus.decodeRun, 0);
    end else begin
      tick();
      check("decodeRun_pulse", bus.decodeRun, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    bus.opHead = 0; bus.BUSRQ = 0; bus.NMI = 0; bus.INT = '0; bus.intMask = '0;
    bus.IMF = 2'b00; bus.setIFF = 0; bus.resetIFF = 0; bus.restoreIFF = 0;
    model_reset();
    repeat (2) tick();
    check("rst_busak", bus.busak, 0);
    check("rst_decodeRun", bus.decodeRun, 0);
    check("rst_iff1", bus.iff1, 0);
    check("rst_intId", bus.intId, 0);
    notReset = 1;
    tick();

    // Plain head, no requests
    head(0, kind);

    // INT = 0110, mode 2 -> channel 1, intMode 100
    iff_op(1);
    head(0, kind);             // consumes the EI head in either build
    bus.INT = 4'b0110; bus.intMask = 4'b0000; bus.IMF = 2'b10;
    head(0, kind);
    bus.INT = '0;

    // BUSRQ and NMI pending together: 5 cycles of bus, then NMI
    iff_op(1);
    head(0, kind);
    nmi_edge();
    head(5, kind);

    // NMI edge coinciding with NMI acceptance stays latched
    nmi_edge();
    bus.NMI = 1;
    head(0, kind);
    m_tnmi = 1;
    bus.NMI = 0;
    tick();
    head(0, kind);

    // Masked channel 3 is ignored, unmasked it wins
    iff_op(1);
    head(0, kind);
    bus.INT = 4'b1000; bus.intMask = 4'b1000; bus.IMF = 2'b01;
    head(0, kind);
    bus.intMask = 4'b0000;
    head(0, kind);
    bus.INT = '0;

    // EI followed directly by a head with INT[0] pending
    iff_op(2);
    bus.INT = 4'b0001; bus.IMF = 2'b00;
    iff_op(1);
    head(0, kind);
    head(0, kind);
    bus.INT = '0;

    // RETN restores iff1 from iff2 after NMI
    iff_op(1);
    head(0, kind);
    nmi_edge();
    head(0, kind);
    iff_op(3);

    // Asynchronous reset in the middle of INTA (ackCnt = 1)
    iff_op(1);
    head(0, kind);
    bus.INT = 4'b0100; bus.IMF = 2'b01;
    bus.opHead = 1; tick(); bus.opHead = 0;
    check("pre_rst_intAck", bus.intAck, 1);
    tick();
    check("pre_rst_intAck2", bus.intAck, 1);
    #1 notReset = 0;
    #1;
    check("arst_busak", bus.busak, 0);
    check("arst_haltXpt", bus.haltXpt, 0);
    check("arst_nmiAck", bus.nmiAck, 0);
    check("arst_intAck", bus.intAck, 0);
    check("arst_intMode", bus.intMode, 0);
    check("arst_intId", bus.intId, 0);
    check("arst_resetHalt", bus.resetHalt, 0);
    check("arst_iff", {bus.iff1, bus.iff2}, 0);
    check("arst_decodeRun", bus.decodeRun, 0);
    bus.INT = '0;
    tick();
    notReset = 1;
    model_reset();
    tick();
    head(0, kind);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      int hold;
      iff_op(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) nmi_edge();
      bus.INT     = N_INT'($urandom);
      bus.intMask = N_INT'($urandom);
      bus.IMF     = 2'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      head(hold, kind);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
